colision_nivel: RTL

COLISION_NIVEL -- requirements
Module: COLISION_NIVEL

---
 rtl/colision_nivel_pkg.sv | 25 ++
 rtl/colision_nivel_contador_pausa.sv | 37 +++
 rtl/colision_nivel.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/colision_nivel_pkg.sv
// Shared game parameters for the frog game: state encodings, initial lives,
// pause length and level codes used by the collision/level controller and the vehicle block.
package colision_nivel_pkg;

    typedef enum logic [2:0] {
        INICIO = 3'd0,
        JUEGO  = 3'd1,
        CHOQUE = 3'd2,
        NIVEL  = 3'd3,
        FIN    = 3'd4,
        GANO   = 3'd5
    } estado_t;

    localparam int VIDAS_INI_DEF    = 3;
    localparam int PAUSA_CICLOS_DEF = 16;

    // Level codes 0..3 stand for levels 1..4.
    localparam int NV_INI = 0;
    localparam int NV_MAX = 3;

    localparam logic [2:0] ROW_LANE_MAX = 3'd5;
    localparam logic [2:0] ROW_SALIDA   = 3'd6;
    localparam logic [2:0] ROW_META     = 3'd7;

endpackage

// File: rtl/colision_nivel_contador_pausa.sv
// Pause counter: loads a start value, counts down to zero and holds there,
// flagging zero so the controller knows when a pause has run its length.
module colision_nivel_contador_pausa #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_d, cnt_q;

    // NOTE: cnt_d gets its hold value first, so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/colision_nivel.sv
// Collision and level controller: detects frog/vehicle hits, tracks lives and
// level, and sequences the INICIO/JUEGO/CHOQUE/NIVEL/FIN/GANO game states.
module colision_nivel
    import colision_nivel_pkg::*;
#(
    parameter int VIDAS_INI        = VIDAS_INI_DEF,
    parameter int PAUSA_CICLOS     = PAUSA_CICLOS_DEF,
    parameter int DATAWIDTH_BUS    = 8,
    parameter int DATAWIDTH_NVL    = 2,
    parameter int DATAWIDTH_ESTADO = 3
) (
    input  logic                        COL_CLOCK,
    input  logic                        COL_RESET,
    input  logic [DATAWIDTH_BUS-1:0]    COL_REG_0_IN,
    input  logic [DATAWIDTH_BUS-1:0]    COL_REG_1_IN,
    input  logic [DATAWIDTH_BUS-1:0]    COL_REG_2_IN,
    input  logic [DATAWIDTH_BUS-1:0]    COL_REG_3_IN,
    input  logic [DATAWIDTH_BUS-1:0]    COL_REG_4_IN,
    input  logic [DATAWIDTH_BUS-1:0]    COL_REG_5_IN,
    input  logic [2:0]                  COL_FROG_ROW_IN,
    input  logic [2:0]                  COL_FROG_COL_IN,
    input  logic                        COL_START_IN,
    output logic [DATAWIDTH_NVL-1:0]    COL_NV_OUT,
    output logic [DATAWIDTH_ESTADO-1:0] COL_ESTADO_OUT,
    output logic                        COL_CN_OUT,
    output logic                        COL_CHOQUE_OUT,
    output logic                        COL_FROG_RST_OUT,
    output logic [1:0]                  COL_VIDAS_OUT
);

    localparam int CNT_W = (PAUSA_CICLOS > 1) ? $clog2(PAUSA_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_CARGA = CNT_W'(PAUSA_CICLOS - 1);

    estado_t                  state_d, state_q;
    logic [DATAWIDTH_NVL-1:0] nv_d, nv_q;
    logic [1:0]               vidas_d, vidas_q;
    logic                     cn_d, cn_q;
    logic                     choque_d, choque_q;
    logic                     frog_rst_d, frog_rst_q;

    logic                     cnt_load, cnt_dec, cnt_zero;
    logic [DATAWIDTH_BUS-1:0] lane;
    logic                     hit;

    colision_nivel_contador_pausa #(
        .W (CNT_W)
    ) u_contador_pausa (
        .clk        (COL_CLOCK),
        .rst        (COL_RESET),
        .load_i     (cnt_load),
        .load_val_i (CNT_CARGA),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        lane = '0;
        case (COL_FROG_ROW_IN)
            3'd0:    lane = COL_REG_0_IN;
            3'd1:    lane = COL_REG_1_IN;
            3'd2:    lane = COL_REG_2_IN;
            3'd3:    lane = COL_REG_3_IN;
            3'd4:    lane = COL_REG_4_IN;
            3'd5:    lane = COL_REG_5_IN;
            default: lane = '0;
        endcase
    end

    // Rows 6 and 7 are safe ground; lanes only matter while actually playing.
    assign hit = (state_q == JUEGO) && (COL_FROG_ROW_IN <= ROW_LANE_MAX)
                 && lane[COL_FROG_COL_IN];

    always_comb begin
        state_d    = state_q;
        nv_d       = nv_q;
        vidas_d    = vidas_q;
        cn_d       = 1'b0;
        choque_d   = 1'b0;
        frog_rst_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            INICIO, FIN, GANO: begin
                if (COL_START_IN) begin
                    state_d    = JUEGO;
                    vidas_d    = 2'(VIDAS_INI);
                    nv_d       = DATAWIDTH_NVL'(NV_INI);
                    cn_d       = 1'b1;
                    frog_rst_d = 1'b1;
                end
            end
            JUEGO: begin
                if (hit) begin
                    state_d    = CHOQUE;
                    vidas_d    = (vidas_q != 2'd0) ? vidas_q - 2'd1 : 2'd0;
                    choque_d   = 1'b1;
                    frog_rst_d = 1'b1;
                    cnt_load   = 1'b1;
                end else if (COL_FROG_ROW_IN == ROW_META) begin
                    // Clearing the last level ends the game without a pause.
                    if (nv_q == DATAWIDTH_NVL'(NV_MAX)) begin
                        state_d = GANO;
                    end else begin
                        state_d    = NIVEL;
                        nv_d       = nv_q + DATAWIDTH_NVL'(1);
                        cn_d       = 1'b1;
                        frog_rst_d = 1'b1;
                        cnt_load   = 1'b1;
                    end
                end
            end
            CHOQUE: begin
                if (cnt_zero) begin
                    state_d = (vidas_q == 2'd0) ? FIN : JUEGO;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            NIVEL: begin
                if (cnt_zero) begin
                    state_d = JUEGO;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = INICIO;
        endcase
    end

    always_ff @(posedge COL_CLOCK or posedge COL_RESET) begin
        if (COL_RESET) begin
            state_q    <= INICIO;
            nv_q       <= DATAWIDTH_NVL'(NV_INI);
            vidas_q    <= 2'(VIDAS_INI);
            cn_q       <= 1'b0;
            choque_q   <= 1'b0;
            frog_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nv_q       <= nv_d;
            vidas_q    <= vidas_d;
            cn_q       <= cn_d;
            choque_q   <= choque_d;
            frog_rst_q <= frog_rst_d;
        end
    end

    assign COL_NV_OUT       = nv_q;
    assign COL_ESTADO_OUT   = DATAWIDTH_ESTADO'(state_q);
    assign COL_CN_OUT       = cn_q;
    assign COL_CHOQUE_OUT   = choque_q;
    assign COL_FROG_RST_OUT = frog_rst_q;
    assign COL_VIDAS_OUT    = vidas_q;

endmodule
